// File: rtl/dot_prod_pkg.sv
// Shared constants, state encoding and width typedefs for the dot-product MAC.
package dot_prod_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_LEN_W  = 8;
    localparam int DEF_ACC_W  = 2 * DEF_DATA_W + DEF_LEN_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic signed [DEF_DATA_W-1:0]   operand_t;
    typedef logic signed [2*DEF_DATA_W-1:0] product_t;
    typedef logic signed [DEF_ACC_W-1:0]    acc_t;

endpackage

// File: rtl/dot_prod_mac_mac_stage.sv
// Two-stage signed MAC: registered product, then sign-extended accumulate.
module mac_stage #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] a_data,
    input  logic signed [DATA_W-1:0] b_data,
    output logic signed [ACC_W-1:0]  acc
);
    localparam int PROD_W = 2 * DATA_W;

    logic signed [PROD_W-1:0] prod_p0;
    logic                     vld_p0;
    logic signed [ACC_W-1:0]  acc_p1;

    function automatic logic signed [ACC_W-1:0] sext(input logic signed [PROD_W-1:0] p);
        return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
    endfunction

    // Stage p0: operand product
    always_ff @(posedge clk) begin
        if (en)
            prod_p0 <= PROD_W'(a_data) * PROD_W'(b_data);
    end

    always_ff @(posedge clk) begin
        if (rst || clr)
            vld_p0 <= 1'b0;
        else
            vld_p0 <= en;
    end

    // Stage p1: accumulate
    always_ff @(posedge clk) begin
        if (rst || clr)
            acc_p1 <= '0;
        else if (vld_p0)
            acc_p1 <= acc_p1 + sext(prod_p0);
    end

    assign acc = acc_p1;

endmodule

// File: rtl/dot_prod_mac.sv
// Streaming signed dot-product engine: length counter, handshake and done-flag controls
// wrapped around the two-stage MAC.
module dot_prod_mac
    import dot_prod_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int ACC_W  = 2 * DATA_W + LEN_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [LEN_W-1:0]         len,
    input  logic signed [DATA_W-1:0] a_data,
    input  logic signed [DATA_W-1:0] b_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [ACC_W-1:0]  result,
    output logic                     result_valid,
    output logic                     busy,
    output logic                     done_en,
    output logic                     done_clr
);
    state_t                  state_q, state_d;
    logic [LEN_W-1:0]        cnt_q, len_q;
    logic                    done_en_q;
    logic                    start_acc;
    logic                    beat;
    logic signed [ACC_W-1:0] acc;

    assign start_acc = !rst && start && (state_q == IDLE || state_q == DONE);
    assign beat      = in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        done_clr = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        done_clr = 1'b1;
                        state_d  = (len == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    in_ready = 1'b1;
                    busy     = 1'b1;
                    if (in_valid && cnt_q == len_q - LEN_W'(1))
                        state_d = DRAIN;
                end
                DRAIN: begin
                    busy    = 1'b1;
                    state_d = DONE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            len_q     <= '0;
            done_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_acc) begin
                cnt_q <= '0;
                len_q <= len;
            end else if (beat) begin
                cnt_q <= cnt_q + LEN_W'(1);
            end
            // Re-entering DONE from DONE via a zero-length start still earns a fresh pulse.
            done_en_q <= (state_d == DONE) && ((state_q != DONE) || start_acc);
        end
    end

    mac_stage #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_acc),
        .en    (beat),
        .a_data(a_data),
        .b_data(b_data),
        .acc   (acc)
    );

    assign result_valid = (state_q == DONE);
    assign result       = result_valid ? acc : '0;
    assign done_en      = done_en_q;

endmodule

// File: tb/tb_dot_prod_mac.sv
// Self-checking bench for dot_prod_mac: vector table, hand sequences and randomized runs
// against an arithmetic sum-of-products model.
module tb_dot_prod_mac;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [7:0]         len = '0;
    logic signed [15:0] a_data = '0;
    logic signed [15:0] b_data = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [39:0] result;
    logic               result_valid;
    logic               busy;
    logic               done_en;
    logic               done_clr;

    int n_tests = 0;
    int n_fail  = 0;
    int op_a[256];
    int op_b[256];

    typedef struct packed {
        int              n;
        int              mode;
        longint          exp;
        logic [7:0][15:0] a;
        logic [7:0][15:0] b;
    } vec_t;

    vec_t vecs[5];

    dot_prod_mac dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .len         (len),
        .a_data      (a_data),
        .b_data      (b_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .result      (result),
        .result_valid(result_valid),
        .busy        (busy),
        .done_en     (done_en),
        .done_clr    (done_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    function automatic vec_t mkv(input int n, input int mode, input longint exp,
                                 input int av[8], input int bv[8]);
        vec_t v;
        v.n = n;
        v.mode = mode;
        v.exp = exp;
        for (int i = 0; i < 8; i++) begin
            v.a[i] = av[i][15:0];
            v.b[i] = bv[i][15:0];
        end
        return v;
    endfunction

    // mode 0: valid held high, 1: valid toggles 1,0,1,..., 2: random valid
    task automatic do_op(input int n, input int mode, input int restart_at,
                         output longint res, output int beats, output int dones,
                         output int clrs, output int rdy, output int lat, output bit tmo);
        int  idx, last, rise;
        bit  got, rs_done, v;
        beats = 0; dones = 0; clrs = 0; rdy = 0; lat = -1; tmo = 0; res = 0;
        idx = 0; last = -1; rise = -1; got = 0; rs_done = 0;
        @(negedge clk);
        start = 1'b1; len = n[7:0]; in_valid = 1'b0;
        #1;
        clrs += int'(done_clr); rdy += int'(in_ready); dones += int'(done_en);
        for (int cyc = 0; cyc < 2000 && !got; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (restart_at >= 0 && idx == restart_at && !rs_done) begin
                start = 1'b1; len = 8'd1; rs_done = 1'b1;
            end
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = $urandom_range(0, 1) == 1;
            endcase
            in_valid = v && (idx < n);
            a_data = op_a[idx < 256 ? idx : 255][15:0];
            b_data = op_b[idx < 256 ? idx : 255][15:0];
            #1;
            clrs += int'(done_clr); dones += int'(done_en); rdy += int'(in_ready);
            if (in_valid && in_ready) begin
                idx++; beats++; last = cyc;
            end
            if (result_valid) begin
                got = 1'b1; rise = cyc; res = result;
            end
        end
        start = 1'b0; in_valid = 1'b0;
        if (!got) tmo = 1'b1;
        else lat = (n == 0) ? rise : rise - last;
        repeat (3) begin
            @(negedge clk);
            #1;
            dones += int'(done_en); clrs += int'(done_clr);
        end
    endtask

    task automatic check_op(input string tag, input int n, input int mode,
                            input int restart_at, input longint exp);
        longint res;
        int beats, dones, clrs, rdy, lat;
        bit tmo;
        do_op(n, mode, restart_at, res, beats, dones, clrs, rdy, lat, tmo);
        chk({tag, ".timeout"}, longint'(tmo), 0);
        chk({tag, ".result"}, res, exp);
        chk({tag, ".beats"}, beats, n);
        chk({tag, ".done_en_pulses"}, dones, 1);
        chk({tag, ".done_clr_pulses"}, clrs, 1);
        chk({tag, ".latency"}, lat, (n == 0) ? 0 : 2);
        if (mode == 0) chk({tag, ".ready_cycles"}, rdy, n);
        chk({tag, ".busy_after"}, longint'(busy), 0);
        chk({tag, ".result_held"}, result, exp);
        chk({tag, ".valid_held"}, longint'(result_valid), 1);
    endtask

    initial begin
        longint exp;
        int     n;
        logic [15:0] r;

        vecs[0] = mkv(4, 0, 70, '{1, 2, 3, 4, 0, 0, 0, 0}, '{5, 6, 7, 8, 0, 0, 0, 0});
        vecs[1] = mkv(3, 0, 64'sd3221225472,
                      '{-32768, -32768, -32768, 0, 0, 0, 0, 0},
                      '{-32768, -32768, -32768, 0, 0, 0, 0, 0});
        vecs[2] = mkv(3, 1, -9, '{2, -3, 4, 0, 0, 0, 0, 0}, '{5, 5, -1, 0, 0, 0, 0, 0});
        vecs[3] = mkv(0, 0, 0, '{0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});
        vecs[4] = mkv(2, 0, 22, '{7, 1, 0, 0, 0, 0, 0, 0}, '{3, 1, 0, 0, 0, 0, 0, 0});

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset.in_ready", longint'(in_ready), 0);
        chk("reset.result", result, 0);
        chk("reset.result_valid", longint'(result_valid), 0);
        chk("reset.busy", longint'(busy), 0);
        chk("reset.done_en", longint'(done_en), 0);
        chk("reset.done_clr", longint'(done_clr), 0);

        // Table-driven vectors
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 8; i++) begin
                op_a[i] = int'($signed(vecs[k].a[i]));
                op_b[i] = int'($signed(vecs[k].b[i]));
            end
            check_op($sformatf("vec%0d", k), vecs[k].n, vecs[k].mode, -1, vecs[k].exp);
        end

        // Start re-issued during RUN is ignored
        for (int i = 0; i < 5; i++) begin
            op_a[i] = i + 1;
            op_b[i] = i + 1;
        end
        check_op("restart", 5, 0, 2, 55);
        @(negedge clk);
        start = 1'b1; len = 8'd3;
        #1;
        chk("restart.clr_from_done", longint'(done_clr), 1);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("restart.valid_dropped", longint'(result_valid), 0);
        chk("restart.busy", longint'(busy), 1);

        // Mid-operation reset aborts without done_en
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start = 1'b1; len = 8'd4;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; a_data = 16'sd1; b_data = 16'sd1;
        repeat (2) @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort.in_ready", longint'(in_ready), 0);
        chk("abort.busy", longint'(busy), 0);
        chk("abort.result", result, 0);
        chk("abort.result_valid", longint'(result_valid), 0);
        begin
            int pulses = int'(done_en);
            repeat (4) begin
                @(negedge clk);
                #1;
                pulses += int'(done_en) + int'(busy);
            end
            chk("abort.no_done_en", pulses, 0);
        end
        op_a[0] = 7; op_a[1] = 1; op_b[0] = 3; op_b[1] = 1;
        check_op("after_abort", 2, 0, -1, 22);

        // Randomized runs against the sum-of-products model
        for (int k = 0; k < 20; k++) begin
            n = $urandom_range(1, 24);
            exp = 0;
            for (int i = 0; i < n; i++) begin
                r = 16'($urandom_range(0, 65535));
                op_a[i] = int'($signed(r));
                r = 16'($urandom_range(0, 65535));
                op_b[i] = int'($signed(r));
                exp += longint'(op_a[i]) * longint'(op_b[i]);
            end
            check_op($sformatf("rand%0d", k), n, 2, -1, exp);
        end

        // Maximum length with the largest-magnitude products
        exp = 0;
        for (int i = 0; i < 255; i++) begin
            op_a[i] = -32768;
            op_b[i] = -32768;
            exp += longint'(op_a[i]) * longint'(op_b[i]);
        end
        check_op("maxlen", 255, 0, -1, exp);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
